mfifo_frame_sender: RTL and testbench
=====================================

# mfifo_frame_sender

Drains a bank of per-channel receive-side FIFOs, one packed output port with per-channel empty flags, into a single framed byte stream for the UART transmitter. It arbitrates round-robin among non-empty channels and pops a burst of up to MAX_BURST bytes from the winner into a local buffer. It then emits one header byte carrying channel id and byte count, followed by the buffered payload, under a valid/ready handshake. It is the transmit-side counterpart of the channel demultiplexer that writes received frames into a single-input, multi-output FIFO bank.

## Interface
- CHANNEL_BIT, 1, log2 of channel count; legal 1..4
- MAX_BURST, 4, max payload bytes per frame; legal 1..16
- WIDTH, 8, data width; fixed at 8
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- fifo_empty  in  2^CHANNEL_BIT  per-channel empty flags from FIFO bank
- fifo_read_data  in  8  head of selected FIFO (show-ahead, valid while !fifo_empty[sel])
- fifo_read_flag  out  1  pop selected FIFO at this clock edge (combinational)
- fifo_read_select  out  CHANNEL_BIT  channel being popped (registered)
- tx_valid  out  1  tx_data valid
- tx_data  out  8  header or payload byte
- tx_ready  in  1  sink accepts tx_data this cycle
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse, last payload byte accepted

## Operation
- Header byte: [7:4] = count-1, [3:0] = channel id zero-extended; count is 1..MAX_BURST.
- Registers: state, sel, last_grant, cnt (0..MAX_BURST), idx, buf[MAX_BURST].
- IDLE: if any fifo_empty bit is 0, grant the first non-empty channel searching last_grant+1, +2, ... with wrap mod 2^CHANNEL_BIT. Latch sel, set cnt=0, go GATHER. Otherwise stay.
- GATHER: if !fifo_empty[sel] && cnt<MAX_BURST, assert fifo_read_flag, write buf[cnt]<=fifo_read_data, cnt++. Else (no pop this cycle) go HEADER.
- HEADER: tx_valid=1, tx_data=header. On tx_valid&&tx_ready go PAYLOAD with idx=0.
- PAYLOAD: tx_valid=1, tx_data=buf[idx]. On handshake: if idx==cnt-1, pulse frame_done, set last_grant=sel, go IDLE. Else idx++.
- fifo_read_flag is asserted only in GATHER. Other channels are never popped.
- tx_data stays stable while tx_valid && !tx_ready. tx_valid never drops without a handshake.
- cnt>=1 is guaranteed on leaving GATHER: the granted FIFO was non-empty and only this block pops it.
- Arrivals on other channels during a frame are served on the next arbitration, in round-robin order.

## Timing
- Reset (RST low, async): state=IDLE, last_grant=2^CHANNEL_BIT-1 (first search starts at channel 0), sel=0, cnt=0, idx=0. Outputs: tx_valid=0, tx_data=0, fifo_read_flag=0, fifo_read_select=0, busy=0, frame_done=0. buf contents don't care.
- Reset mid-frame drops buffered bytes. Bytes already popped are lost; no partial frame is resumed.
- Non-empty channel seen in IDLE at cycle 0: pops occur in cycles 1..n.
- If the burst ends by empty, the empty check is in cycle n+1 and the header is valid at cycle n+2.
- If the burst ends by cnt==MAX_BURST, the check is in cycle MAX_BURST+1 and the header is valid at MAX_BURST+2.
- With tx_ready held high, the frame occupies count+1 consecutive cycles. frame_done is in the cycle the last byte handshakes, and IDLE follows.
- Minimum gap: one IDLE cycle between frames.

## Test plan
- Reset: assert RST low mid-GATHER with bytes pending -> all outputs at reset values immediately. After release, the next frame starts from channel 0.
- Single frame: CHANNEL_BIT=1, MAX_BURST=4, ch1 holds 0xA1,0xA2, tx_ready=1 -> pops in cycles 1–2, header 0x11 at cycle 4, then 0xA1, 0xA2, with frame_done on the 0xA2 cycle.
- Burst split: ch0 holds 6 bytes 0x00..0x05 -> frame 0x30,0x00..0x03, then frame 0x10,0x04,0x05.
- Round robin: ch0 holds 6 bytes, ch1 holds 0xB0 -> frames in order ch0(4 bytes), ch1 (0x01,0xB0), ch0(2 bytes).
- Backpressure: tx_ready toggled 1,0,0,1,... during a 3-byte frame -> tx_data stable while stalled, order 0x21,b0,b1,b2, no duplicates or drops.
- Idle: all fifo_empty=1 for 20 cycles -> busy=0, tx_valid=0, fifo_read_flag=0 throughout.

Source files
------------

// File: rtl/mfifo_frame_sender.sv
// Round-robin drain of a per-channel FIFO bank into a framed byte stream:
// one header byte {count-1, channel} followed by up to MAX_BURST payload bytes.
module mfifo_frame_sender #(
    parameter int CHANNEL_BIT = 1,
    parameter int MAX_BURST   = 4,
    parameter int WIDTH       = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [(1<<CHANNEL_BIT)-1:0] fifo_empty,
    input  logic [WIDTH-1:0]            fifo_read_data,
    output logic                        fifo_read_flag,
    output logic [CHANNEL_BIT-1:0]      fifo_read_select,
    output logic                        tx_valid,
    output logic [WIDTH-1:0]            tx_data,
    input  logic                        tx_ready,
    output logic                        busy,
    output logic                        frame_done,
    output logic [1:0]                  dbg_state
);

    localparam int NCH   = 1 << CHANNEL_BIT;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GATHER  = 2'd1;
    localparam logic [1:0] HEADER  = 2'd2;
    localparam logic [1:0] PAYLOAD = 2'd3;

    logic [1:0]             state;
    logic [CHANNEL_BIT-1:0] sel;
    logic [CHANNEL_BIT-1:0] last_grant;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [WIDTH-1:0]       pay_buf [MAX_BURST];

    logic                   grant_found;
    logic [CHANNEL_BIT-1:0] grant_ch;
    logic [CHANNEL_BIT-1:0] cand;
    logic                   last_byte;

    // Search from last_grant+1 upward with wrap; iterating farthest-first lets
    // the nearest non-empty channel overwrite the result and win.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int k = NCH; k >= 1; k--) begin
            cand = last_grant + CHANNEL_BIT'(k);
            if (!fifo_empty[cand]) begin
                grant_found = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    assign fifo_read_flag   = (state == GATHER) && !fifo_empty[sel] && (cnt < MAX_CNT);
    assign fifo_read_select = sel;
    assign busy             = (state != IDLE);
    assign dbg_state        = state;
    assign last_byte        = (CNT_W'(idx) == (cnt - ONE_CNT));

    // Handshake: tx_valid/tx_data are pure functions of registered state, so the
    // byte holds steady until tx_valid && tx_ready is seen at a rising edge.
    assign tx_valid   = (state == HEADER) || (state == PAYLOAD);
    assign frame_done = (state == PAYLOAD) && tx_ready && last_byte;

    always_comb begin
        tx_data = '0;
        if (state == HEADER)
            tx_data = {4'(cnt - ONE_CNT), 4'(sel)};
        else if (state == PAYLOAD)
            tx_data = pay_buf[idx];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            sel        <= '0;
            last_grant <= '1;
            cnt        <= '0;
            idx        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        sel   <= grant_ch;
                        cnt   <= '0;
                        state <= GATHER;
                    end
                end
                GATHER: begin
                    if (fifo_read_flag)
                        cnt <= cnt + ONE_CNT;
                    else
                        state <= HEADER;
                end
                HEADER: begin
                    if (tx_ready) begin
                        idx   <= '0;
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (tx_ready) begin
                        if (last_byte) begin
                            last_grant <= sel;
                            state      <= IDLE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload storage needs no reset: a frame only reads slots it has written.
    always_ff @(posedge CLK) begin
        if (fifo_read_flag)
            pay_buf[IDX_W'(cnt)] <= fifo_read_data;
    end

endmodule

// File: tb/tb_mfifo_frame_sender.sv
// Directed bench for mfifo_frame_sender (CHANNEL_BIT=1, MAX_BURST=4) driving a
// show-ahead two-channel FIFO bank model.
module tb_mfifo_frame_sender;

    logic       CLK;
    logic       RST;
    logic [1:0] fifo_empty;
    logic [7:0] fifo_read_data;
    logic       fifo_read_flag;
    logic [0:0] fifo_read_select;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       frame_done;
    logic [1:0] dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    int bad_pop     = 0;

    logic [7:0] mem [2][256];
    logic [7:0] rd_ptr [2] = '{8'd0, 8'd0};
    logic [7:0] wr_ptr [2] = '{8'd0, 8'd0};

    logic [7:0] bp_data [10] = '{8'h21, 8'hD0, 8'hD0, 8'hD0, 8'hD1, 8'hD1, 8'hD1, 8'hD2, 8'hD2, 8'hD2};
    logic       bp_rdy  [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    mfifo_frame_sender #(
        .CHANNEL_BIT(1),
        .MAX_BURST  (4),
        .WIDTH      (8)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .fifo_empty      (fifo_empty),
        .fifo_read_data  (fifo_read_data),
        .fifo_read_flag  (fifo_read_flag),
        .fifo_read_select(fifo_read_select),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready),
        .busy            (busy),
        .frame_done      (frame_done),
        .dbg_state       (dbg_state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always_comb begin
        for (int c = 0; c < 2; c++)
            fifo_empty[c] = (rd_ptr[c] == wr_ptr[c]);
    end

    assign fifo_read_data = mem[fifo_read_select][rd_ptr[fifo_read_select]];

    always @(posedge CLK) begin
        if (fifo_read_flag) begin
            if (fifo_empty[fifo_read_select])
                bad_pop = bad_pop + 1;
            else
                rd_ptr[fifo_read_select] <= rd_ptr[fifo_read_select] + 8'd1;
        end
    end

    task automatic push(input int ch, input logic [7:0] b);
        mem[ch][wr_ptr[ch]] = b;
        wr_ptr[ch] = wr_ptr[ch] + 8'd1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for tx_valid with tx_ready high, checks the byte, then
    // steps past the handshake edge.
    task automatic recv(input string tag, input logic [7:0] exp_data, input logic exp_done);
        int waited = 0;
        while (!tx_valid && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        check({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, tx_data}, {24'd0, exp_data});
        check({tag, "_done"}, {31'd0, frame_done}, {31'd0, exp_done});
        @(negedge CLK);
    endtask

    initial begin
        RST      = 1'b0;
        tx_ready = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_read_flag", {31'd0, fifo_read_flag}, 32'd0);
        check("rst_read_select", {31'd0, fifo_read_select}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // Single frame on ch1: pops at cycles 1-2, check at 3, header at 4.
        push(1, 8'hA1);
        push(1, 8'hA2);
        @(negedge CLK);
        check("sf_pop1_flag", {31'd0, fifo_read_flag}, 32'd1);
        check("sf_pop1_sel", {31'd0, fifo_read_select}, 32'd1);
        check("sf_pop1_valid", {31'd0, tx_valid}, 32'd0);
        @(negedge CLK);
        check("sf_pop2_flag", {31'd0, fifo_read_flag}, 32'd1);
        @(negedge CLK);
        check("sf_chk_flag", {31'd0, fifo_read_flag}, 32'd0);
        check("sf_chk_busy", {31'd0, busy}, 32'd1);
        check("sf_chk_valid", {31'd0, tx_valid}, 32'd0);
        @(negedge CLK);
        check("sf_hdr_valid", {31'd0, tx_valid}, 32'd1);
        check("sf_hdr_data", {24'd0, tx_data}, 32'h11);
        @(negedge CLK);
        check("sf_b0_data", {24'd0, tx_data}, 32'hA1);
        check("sf_b0_done", {31'd0, frame_done}, 32'd0);
        @(negedge CLK);
        check("sf_b1_data", {24'd0, tx_data}, 32'hA2);
        check("sf_b1_done", {31'd0, frame_done}, 32'd1);
        @(negedge CLK);
        check("sf_after_busy", {31'd0, busy}, 32'd0);
        check("sf_after_valid", {31'd0, tx_valid}, 32'd0);

        // Backpressure on a 3-byte ch1 frame.
        tx_ready = 1'b0;
        push(1, 8'hD0);
        push(1, 8'hD1);
        push(1, 8'hD2);
        for (int i = 0; i < 20 && !tx_valid; i++) @(negedge CLK);
        check("bp_wait_valid", {31'd0, tx_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tx_ready = bp_rdy[i];
            #1;
            check($sformatf("bp_step%0d_valid", i), {31'd0, tx_valid}, 32'd1);
            check($sformatf("bp_step%0d_data", i), {24'd0, tx_data}, {24'd0, bp_data[i]});
            check($sformatf("bp_step%0d_done", i), {31'd0, frame_done}, (i == 9) ? 32'd1 : 32'd0);
            @(negedge CLK);
        end
        tx_ready = 1'b1;
        check("bp_end_valid", {31'd0, tx_valid}, 32'd0);

        // Round robin: last grant is ch1, so ch0 goes first.
        for (int i = 0; i < 6; i++) push(0, 8'h40 + 8'(i));
        push(1, 8'hB0);
        recv("rr_f0_hdr", 8'h30, 1'b0);
        recv("rr_f0_b0", 8'h40, 1'b0);
        recv("rr_f0_b1", 8'h41, 1'b0);
        recv("rr_f0_b2", 8'h42, 1'b0);
        recv("rr_f0_b3", 8'h43, 1'b1);
        recv("rr_f1_hdr", 8'h01, 1'b0);
        recv("rr_f1_b0", 8'hB0, 1'b1);
        recv("rr_f2_hdr", 8'h10, 1'b0);
        recv("rr_f2_b0", 8'h44, 1'b0);
        recv("rr_f2_b1", 8'h45, 1'b1);

        // Burst split of six ch0 bytes.
        for (int i = 0; i < 6; i++) push(0, 8'(i));
        recv("bs_f0_hdr", 8'h30, 1'b0);
        recv("bs_f0_b0", 8'h00, 1'b0);
        recv("bs_f0_b1", 8'h01, 1'b0);
        recv("bs_f0_b2", 8'h02, 1'b0);
        recv("bs_f0_b3", 8'h03, 1'b1);
        recv("bs_f1_hdr", 8'h10, 1'b0);
        recv("bs_f1_b0", 8'h04, 1'b0);
        recv("bs_f1_b1", 8'h05, 1'b1);

        // Idle with every FIFO empty.
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("idle_%0d", i), {29'd0, busy, tx_valid, fifo_read_flag}, 32'd0);
            @(negedge CLK);
        end

        // Reset mid-GATHER after one pop: 0x60 is lost, arbitration restarts at ch0.
        for (int i = 0; i < 6; i++) push(0, 8'h60 + 8'(i));
        @(negedge CLK);
        check("rt_pop1_flag", {31'd0, fifo_read_flag}, 32'd1);
        @(negedge CLK);
        check("rt_pop2_flag", {31'd0, fifo_read_flag}, 32'd1);
        RST = 1'b0;
        #1;
        check("rt_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rt_tx_data", {24'd0, tx_data}, 32'd0);
        check("rt_read_flag", {31'd0, fifo_read_flag}, 32'd0);
        check("rt_read_select", {31'd0, fifo_read_select}, 32'd0);
        check("rt_busy", {31'd0, busy}, 32'd0);
        check("rt_frame_done", {31'd0, frame_done}, 32'd0);
        push(1, 8'hC0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        recv("rt_f0_hdr", 8'h30, 1'b0);
        recv("rt_f0_b0", 8'h61, 1'b0);
        recv("rt_f0_b1", 8'h62, 1'b0);
        recv("rt_f0_b2", 8'h63, 1'b0);
        recv("rt_f0_b3", 8'h64, 1'b1);
        recv("rt_f1_hdr", 8'h01, 1'b0);
        recv("rt_f1_b0", 8'hC0, 1'b1);
        recv("rt_f2_hdr", 8'h00, 1'b0);
        recv("rt_f2_b0", 8'h65, 1'b1);

        repeat (3) @(negedge CLK);
        check("end_bad_pops", bad_pop, 32'd0);
        check("end_fifos_drained", {30'd0, fifo_empty}, 32'd3);
        check("end_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
